// File: rtl/lift_call_queue_pkg.sv
// lift_call_queue_pkg: floor count, lift state codes and target selection helper.
package lift_call_queue_pkg;

  localparam int unsigned NUM_FLOORS = 3;
  localparam int unsigned FLOOR_W    = 2;

  // Lift FSM state codes seen on katastash: S0..S2 stationary at floor, S3 up, S4 down, S5 doors open
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } kata_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } queue_state_t;

  // Nearest requested floor to cur; strict compare in ascending order keeps the lower floor on ties
  function automatic logic [FLOOR_W-1:0] pick_target(input logic [NUM_FLOORS-1:0] req,
                                                      input logic [FLOOR_W-1:0]    cur);
    logic [FLOOR_W-1:0] best;
    logic [FLOOR_W-1:0] best_d;
    logic [FLOOR_W-1:0] d;
    best   = '0;
    best_d = '1;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      d = (FLOOR_W'(i) > cur) ? (FLOOR_W'(i) - cur) : (cur - FLOOR_W'(i));
      if (req[FLOOR_W'(i)] && (d < best_d)) begin
        best   = FLOOR_W'(i);
        best_d = d;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/lift_call_queue_debouncer.sv
// call_debouncer: 2-FF synchroniser, debounce filter and press edge detect for one button.
module call_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb cnt_next = cnt + CNT_W'(1);

  // Synchronise, then accept the synced level once it has differed from the accepted one for
  // DEBOUNCE_CYCLES consecutive cycles. For a single bit any change while counting returns to
  // the accepted level, so zeroing on agreement is the reload on change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt_next >= CNT_W'(DEBOUNCE_CYCLES)) begin
        stable <= sync2;
        press  <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/lift_call_queue.sv
// lift_call_queue: debounced floor requests, pending latch, nearest-target selector and call FSM.
// Optional serve watchdog enabled by defining CALL_TIMEOUT_EN.
module lift_call_queue
  import lift_call_queue_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [2:0]            katastash,
  input  logic                  doors,
  output logic                  call_0,
  output logic                  call_1,
  output logic                  call_2,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy,
  output logic                  timeout
);

  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] press_ok;
  logic [NUM_FLOORS-1:0] pending_next;
  logic [NUM_FLOORS-1:0] calls;
  logic [NUM_FLOORS-1:0] sel_onehot;
  logic [FLOOR_W-1:0]    cur_floor;
  logic [FLOOR_W-1:0]    target;
  logic [FLOOR_W-1:0]    sel;
  logic                  serve_done;
  logic                  wd_fire;
  queue_state_t          state;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_deb
    call_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[g]),
      .press(press[g])
    );
  end

  assign {call_2, call_1, call_0} = calls;

  // Press filtering, clear-on-doors and watchdog clear; clears override presses on the same bit
  always_comb begin
    press_ok     = '0;
    serve_done   = (state == SERVE) && doors && (cur_floor == target);
    sel          = pick_target(pending, cur_floor);
    sel_onehot   = NUM_FLOORS'(1) << sel;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      press_ok[FLOOR_W'(i)] = press[FLOOR_W'(i)]
                              && (katastash != 3'(i))
                              && !(doors && (cur_floor == FLOOR_W'(i)));
    end
    pending_next = pending | press_ok;
    if (doors) begin
      pending_next[cur_floor] = 1'b0;
    end
    if (wd_fire) begin
      pending_next[target] = 1'b0;
    end
  end

  // Floor tracker and pending request register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_floor <= '0;
      pending   <= '0;
    end else begin
      if ((katastash == S0) || (katastash == S1) || (katastash == S2)) begin
        cur_floor <= katastash[FLOOR_W-1:0];
      end
      pending <= pending_next;
    end
  end

  // Call FSM: latch a target from pending while idle, hold its call until served
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      target <= '0;
      calls  <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending != '0) begin
            state  <= SERVE;
            target <= sel;
            calls  <= sel_onehot;
            busy   <= 1'b1;
          end
        end
        SERVE: begin
          if (serve_done || wd_fire) begin
            state <= IDLE;
            calls <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          calls <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CALL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  always_comb wd_fire = (state == SERVE) && !serve_done
                        && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Serve watchdog: counts SERVE cycles, zero otherwise; pulses timeout on expiry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= wd_fire;
      if ((state == SERVE) && !serve_done && !wd_fire) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end
    end
  end
`else
  always_comb wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lift_call_queue.sv
// tb_lift_call_queue: randomized + directed stimulus, reference model feeding a timestamped
// scoreboard, monitor comparing on every DUT output change.
module tb_lift_call_queue;

  localparam int D = 4;
  localparam int T = 64;
`ifdef CALL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] btn = '0;
  logic [2:0] katastash = '0;
  logic       doors = 1'b0;
  logic       call_0, call_1, call_2, busy, timeout;
  logic [2:0] pending;

  lift_call_queue #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .katastash(katastash),
    .doors    (doors),
    .call_0   (call_0),
    .call_1   (call_1),
    .call_2   (call_2),
    .pending  (pending),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] pend;
    logic [2:0] calls;
    logic       busy;
    logic       tmo;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  exp_t       sbq[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  snap_t      mon_prev = '0;
  snap_t      mon_now;

  // reference model state
  logic [2:0] hist[$];
  logic [2:0] m_stable = '0;
  logic [2:0] m_press = '0;
  logic [2:0] m_pend = '0;
  int         m_cur = 0;
  bit         m_serving = 1'b0;
  int         m_tgt = 0;
  int         m_scnt = 0;
  bit         m_tmo = 1'b0;
  snap_t      m_prev = '0;

  function automatic int nearest(input logic [2:0] req, input int cur);
    for (int d = 0; d < 3; d++) begin
      if ((cur - d >= 0) && req[cur-d]) return cur - d;
      if ((cur + d <= 2) && req[cur+d]) return cur + d;
    end
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  initial begin
    for (int k = 0; k < D + 2; k++) hist.push_back(3'b000);
  end

  // Reference model: a button level counts once D consecutive synchronised samples agree
  always @(posedge clk or negedge reset) begin : model
    logic [2:0] new_press;
    logic [2:0] np;
    bit         all1, all0, fire;
    snap_t      snap;
    if (!reset) begin
      hist.delete();
      for (int k = 0; k < D + 2; k++) hist.push_back(3'b000);
      m_stable = '0; m_press = '0; m_pend = '0; m_cur = 0;
      m_serving = 1'b0; m_tgt = 0; m_scnt = 0; m_tmo = 1'b0; m_prev = '0;
    end else begin
      cyc++;
      hist.push_front(btn);
      void'(hist.pop_back());
      new_press = '0;
      for (int i = 0; i < 3; i++) begin
        all1 = 1'b1; all0 = 1'b1;
        for (int k = 2; k <= D + 1; k++) begin
          if (hist[k][i]) all0 = 1'b0;
          else all1 = 1'b0;
        end
        if (all1 && !m_stable[i]) begin m_stable[i] = 1'b1; new_press[i] = 1'b1; end
        if (all0) m_stable[i] = 1'b0;
      end
      np = m_pend;
      for (int i = 0; i < 3; i++)
        if (m_press[i] && (int'(katastash) != i) && !(doors && m_cur == i)) np[i] = 1'b1;
      if (doors) np[m_cur] = 1'b0;
      fire = 1'b0;
      if (m_serving) begin
        if (doors && m_cur == m_tgt) m_serving = 1'b0;
        else begin
          m_scnt++;
          if (TMO_EN && m_scnt == T) begin
            fire = 1'b1; m_serving = 1'b0; np[m_tgt] = 1'b0;
          end
        end
      end else if (m_pend != 3'b000) begin
        m_serving = 1'b1; m_tgt = nearest(m_pend, m_cur); m_scnt = 0;
      end
      if (katastash <= 3'd2) m_cur = int'(katastash);
      m_pend  = np;
      m_press = new_press;
      m_tmo   = fire;
      snap.pend  = m_pend;
      snap.calls = m_serving ? 3'(1 << m_tgt) : 3'b000;
      snap.busy  = m_serving;
      snap.tmo   = m_tmo;
      if (snap != m_prev) sbq.push_back('{cyc: cyc, s: snap});
      m_prev = snap;
    end
  end

  // Monitor: every DUT output change must match the next expected change, at the same cycle
  always @(negedge clk) begin
    if (mon_en) begin
      mon_now = {pending, call_2, call_1, call_0, busy, timeout};
      if (mon_now !== mon_prev) begin
        n_checks++;
        if (sbq.size() == 0) begin
          $display("FAIL out_change: actual %b at cycle %0d, required no change", mon_now, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (mon_now === e.s && cyc == e.cyc) n_pass++;
          else $display("FAIL out_change: actual %b at cycle %0d, required %b at cycle %0d",
                        mon_now, cyc, e.s, e.cyc);
        end
        mon_prev = mon_now;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    btn = '0; katastash = '0; doors = 1'b0;
    #1 check("reset_outputs", int'({pending, call_2, call_1, call_0, busy, timeout}), 0);
    sbq.delete();
    mon_prev = '0;
    mon_en   = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic drive(input logic [2:0] b, input logic [2:0] k, input logic d, input int n);
    btn = b; katastash = k; doors = d;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    do_reset();
    // press floor 2 from floor 0, then travel up and open doors at 2
    drive(3'b100, 3'd0, 1'b0, 10);
    drive(3'b000, 3'd0, 1'b0, 4);
    drive(3'b000, 3'd3, 1'b0, 3);
    drive(3'b000, 3'd2, 1'b0, 2);
    drive(3'b000, 3'd5, 1'b1, 1);
    drive(3'b000, 3'd2, 1'b0, 4);
    // glitches on floor 1 shorter than the debounce window
    for (int g = 0; g < 4; g++) begin
      drive(3'b010, 3'd2, 1'b0, 1);
      drive(3'b000, 3'd2, 1'b0, 1);
    end
    drive(3'b010, 3'd2, 1'b0, D - 1);
    drive(3'b000, 3'd2, 1'b0, 10);
    // move to floor 0, then a press there while stationary is dropped
    drive(3'b000, 3'd4, 1'b0, 3);
    drive(3'b000, 3'd0, 1'b0, 3);
    drive(3'b001, 3'd0, 1'b0, 8);
    drive(3'b000, 3'd0, 1'b0, 6);
    // from floor 1, simultaneous floor 0 and floor 2 requests: tie resolves to floor 0
    drive(3'b000, 3'd3, 1'b0, 2);
    drive(3'b000, 3'd1, 1'b0, 3);
    drive(3'b101, 3'd1, 1'b0, 8);
    drive(3'b000, 3'd1, 1'b0, 4);
    drive(3'b000, 3'd4, 1'b0, 2);
    drive(3'b000, 3'd0, 1'b0, 1);
    drive(3'b000, 3'd5, 1'b1, 1);
    drive(3'b000, 3'd0, 1'b0, 4);
    // floor 2 now being served: reset mid-serve
    do_reset();
    drive(3'b000, 3'd0, 1'b0, 3);
    // randomized traffic
    for (int s = 0; s < 600; s++) begin
      int unsigned len;
      len = $urandom_range(1, 8);
      drive(($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0),
            int'(len));
      if (s == 300) do_reset();
    end
    drive(3'b000, 3'd0, 1'b0, 30);
    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
